// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan serializer.
// No logic of its own; the select range helpers depend on scan direction.
// Imported by the top level.
package mux_scan_pkg;

   localparam int SEL_W = 4;

   // ST_PARITY is only reachable when the parity feature is compiled in.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_DONE   = 2'd2,
      ST_PARITY = 2'd3
   } state_t;

   // First select code of a frame for the given scan direction.
   function automatic logic [SEL_W-1:0] sel_first(input bit msb_first);
      return msb_first ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
   endfunction

   // Last select code of a frame; the counter never steps past it.
   function automatic logic [SEL_W-1:0] sel_last(input bit msb_first);
      return msb_first ? {SEL_W{1'b0}} : {SEL_W{1'b1}};
   endfunction

endpackage

// File: rtl/mux_scan_serializer_if.sv
// Load and serial-stream handshake bundle for the mux scan serializer.
// Pure wiring, no latency.
// Both ports use valid/ready; the stream side stalls on ser_ready low.
interface mux_scan_serializer_if;

   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic        ser_o;
   logic        ser_valid;
   logic        ser_ready;
   logic [3:0]  sel_o;
   logic        done;

   // Upstream producer / downstream consumer side.
   modport master (
      output load_valid, load_data, ser_ready,
      input  load_ready, ser_o, ser_valid, sel_o, done
   );

   // Serializer side.
   modport slave (
      input  load_valid, load_data, ser_ready,
      output load_ready, ser_o, ser_valid, sel_o, done
   );

endinterface

// File: rtl/mux_16x1_sel.sv
// Combinational 16:1 bit selector.
// Zero latency.
// No handshake; output follows in/sel directly.
module mux_16x1_sel (
   input  logic [15:0] in,
   input  logic [3:0]  sel,
   output logic        o
);

   assign o = in[sel];

endmodule

// File: rtl/mux_scan_serializer.sv
// Walks a 4-bit mux select over a captured 16-bit word, emitting one bit per
// accepted handshake, then pulses done. Bit 0 appears the cycle after the load;
// ser_ready low freezes select and output. Optional: MUX_SCAN_PARITY_EN appends
// an even-parity bit after the last data bit.
module mux_scan_serializer
   import mux_scan_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0,
   parameter int DATA_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   mux_scan_serializer_if.slave  bus
);

   localparam logic [SEL_W-1:0] SEL_FIRST = sel_first(MSB_FIRST);
   localparam logic [SEL_W-1:0] SEL_LAST  = sel_last(MSB_FIRST);
   localparam logic [SEL_W-1:0] SEL_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};

   state_t              state_q;
   state_t              state_d;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   data_d;
   logic [SEL_W-1:0]    sel_q;
   logic [SEL_W-1:0]    sel_d;

   logic                mux_bit;
   logic                load_ready;
   logic                ser_valid;
   logic                ser_bit;
   logic                done;

   // Selected data bit for the current code; the registered data and select
   // feed the mux directly so the bit is valid in the same cycle as sel.
   mux_16x1_sel u_sel (
      .in  (data_q),
      .sel (sel_q),
      .o   (mux_bit)
   );

   // State, captured word and select counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

   // Next state, counter stepping and handshake outputs.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      sel_d      = sel_q;
      load_ready = 1'b0;
      ser_valid  = 1'b0;
      ser_bit    = 1'b0;
      done       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            load_ready = 1'b1;
            if (bus.load_valid) begin
               data_d  = bus.load_data;
               sel_d   = SEL_FIRST;
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            ser_valid = 1'b1;
            ser_bit   = mux_bit;
            // Select only moves on an accepted bit and stops at the last code,
            // so sel_o keeps pointing at the final bit through DONE and IDLE.
            if (bus.ser_ready) begin
               if (sel_q == SEL_LAST) begin
`ifdef MUX_SCAN_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_DONE;
`endif
               end else if (MSB_FIRST) begin
                  sel_d = sel_q - SEL_ONE;
               end else begin
                  sel_d = sel_q + SEL_ONE;
               end
            end
         end

`ifdef MUX_SCAN_PARITY_EN
         ST_PARITY: begin
            ser_valid = 1'b1;
            ser_bit   = ^data_q;
            if (bus.ser_ready) begin
               state_d = ST_DONE;
            end
         end
`endif

         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.load_ready = load_ready;
   assign bus.ser_valid  = ser_valid;
   assign bus.ser_o      = ser_bit;
   assign bus.sel_o      = sel_q;
   assign bus.done       = done;

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
Upstream select-sequencing stage for the 16:1 mux path. Accepts a 16-bit word over a valid/ready load port and drives the select lines through codes 0..15 (or 15..0). Emits the selected bit serially over a valid/ready stream, then pulses done. Converts the combinational 16:1 selection into a self-timed parallel-to-serial converter.

Parameters:
MSB_FIRST, 0, 0: select walks 0->15 (LSB first); 1: select walks 15->0.
DATA_W, 16, word width; fixed at 16 in this revision, because the select counter is fixed at 4 bits.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
load_valid  input  1  upstream presents load_data.
load_ready  output  1  block can accept a word.
load_data  input  16  parallel word to serialize.
ser_o  output  1  current serial bit; 0 when ser_valid=0.
ser_valid  output  1  ser_o is valid.
ser_ready  input  1  downstream accepts ser_o this cycle.
sel_o  output  4  current mux select code, exported for observation.
done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Reset (rst=1 at an edge) has priority over all other inputs:
  - state=IDLE, data register=0, sel=0, done=0.
  - Resulting outputs: load_ready=1, ser_valid=0, ser_o=0, sel_o=0.
- FSM states are IDLE, SHIFT, DONE (plus PARITY when PARITY_EN is defined).
- IDLE:
  - load_ready=1, ser_valid=0.
  - On load_valid=1: capture load_data, set sel = MSB_FIRST ? 15 : 0, go to SHIFT.
- SHIFT:
  - load_ready=0, ser_valid=1.
  - ser_o = data[sel], combinational from registered data and sel (no extra latency).
  - On ser_ready=1 with sel not last: sel steps by +1 (or -1 when MSB_FIRST=1).
  - On ser_ready=1 with sel last (15, or 0 when MSB_FIRST=1): go to DONE.
  - On ser_ready=0: hold sel, ser_o and ser_valid (AXI-style stall).
- DONE:
  - done=1 for exactly one cycle; ser_valid=0, load_ready=0.
  - Next state is IDLE.
- Latency, load accepted at edge N:
  - ser_valid=1 from cycle N+1.
  - With ser_ready held high, the 16 bits occupy cycles N+1..N+16.
  - done=1 in cycle N+17; load_ready=1 again in cycle N+18.
- load_valid outside IDLE is ignored; load_data is not sampled.
- sel never wraps within a frame. The counter only moves on a ser_ready handshake in SHIFT.
- sel_o holds its last value in DONE and IDLE until the next load.
- Reset asserted mid-frame aborts the frame: no done pulse, and partial output is discarded.

Optional Feature:
Macro MUX_SCAN_PARITY_EN.
- Defined:
  - After the last data bit is accepted, enter PARITY state: ser_valid=1, ser_o = ^data (even-parity bit), sel_o holds the last code.
  - On ser_ready=1, go to DONE.
  - Frame is 17 bits; with ser_ready high, done lands in cycle N+18.
- Undefined: PARITY state and logic are absent; frame is 16 bits.

Decomposition:
- Shared package mux_scan_pkg holds:
  - the state enum/localparams (ST_IDLE, ST_SHIFT, ST_DONE, ST_PARITY);
  - SEL_W=4, SEL_FIRST/SEL_LAST constants derived from MSB_FIRST.
- One sub-module is natural: mux_16x1_sel, a pure combinational 16:1 selector (in[15:0], sel[3:0] -> o) instantiated for ser_o.
- FSM and counter stay in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles -> load_ready=1, ser_valid=0, ser_o=0, sel_o=0, done=0.
- Basic LSB-first: load 16'd43160 (16'hA898), ser_ready=1 -> ser_o sequence 0,0,0,1,1,0,0,1,0,0,0,1,0,1,0,1 over cycles N+1..N+16, sel_o 0..15, done pulse in N+17 only.
- Backpressure: same word, ser_ready=0 on cycles N+3..N+5 -> sel_o holds 2 and ser_o holds 0 for those cycles; sequence resumes unchanged; done in N+20.
- Ignored load plus mid-frame reset:
  - Assert load_valid with 16'hFFFF during SHIFT -> bit stream unchanged.
  - Then rst=1 at sel=7 -> IDLE next cycle, no done pulse.
  - A fresh load then starts at sel=0.
- MSB_FIRST=1: load 16'hA898 -> ser_o 1,0,1,0,1,0,0,0,1,0,0,1,1,0,0,0 with sel_o 15..0.
- MUX_SCAN_PARITY_EN defined: load 16'hA898 -> bit 17 = 0 (popcount 6); load 16'h0001 -> bit 17 = 1; done in N+18.
